// File: rtl/ex_div_ctrl.sv
// EX-stage divide sequencer: launches the iterative divider, stalls EX until it returns, then drives the HI/LO write.
// Build option DIV_WATCHDOG_EN adds a BUSY-cycle watchdog that aborts a divider that never reports ready.
module ex_div_ctrl #(
    parameter int WDOG_LIMIT = 48
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        div_req_i,
    input  logic        div_signed_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_opdata1_o,
    output logic [31:0] div_opdata2_o,
    input  logic [63:0] div_result_i,
    input  logic        div_ready_i,
    output logic        stallreq_o,
    output logic        whilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        div_err_o
);

    typedef enum logic [1:0] {IDLE, ZERO, BUSY, DONE} state_t;

    state_t      state;
    state_t      state_nx;
    logic        accept;
    logic        wdog_hit;
    logic [63:0] result;

    if (WDOG_LIMIT < 2 || WDOG_LIMIT > 64) begin : g_bad_limit
        $error("WDOG_LIMIT must fit the 6-bit watchdog counter");
    end

`ifdef DIV_WATCHDOG_EN
    logic [5:0] wdog_cnt;
    logic       err;

    // Counter sits at zero outside BUSY, so it starts from zero on every BUSY entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wdog_cnt <= 6'd0;
            err      <= 1'b0;
        end else begin
            wdog_cnt <= (state == BUSY) ? wdog_cnt + 6'd1 : 6'd0;
            if (accept)
                err <= 1'b0;
            else if (wdog_hit)
                err <= 1'b1;
        end
    end

    assign wdog_hit  = (state == BUSY) & ~flush_i & ~div_ready_i &
                       (wdog_cnt == 6'(WDOG_LIMIT - 1));
    assign div_err_o = err;
`else
    assign wdog_hit  = 1'b0;
    assign div_err_o = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            div_signed_o  <= 1'b0;
            div_opdata1_o <= 32'd0;
            div_opdata2_o <= 32'd0;
            result        <= 64'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                div_signed_o  <= div_signed_i;
                div_opdata1_o <= opdata1_i;
                div_opdata2_o <= opdata2_i;
            end
            if (state == ZERO)
                result <= 64'd0;
            else if (state == BUSY && !flush_i && div_ready_i)
                result <= div_result_i;
            else if (wdog_hit)
                result <= 64'd0;
        end
    end

    always_comb begin
        state_nx    = state;
        accept      = 1'b0;
        div_annul_o = 1'b0;
        case (state)
            IDLE: begin
                if (div_req_i && !flush_i) begin
                    accept   = 1'b1;
                    state_nx = (opdata2_i == 32'd0) ? ZERO : BUSY;
                end
            end
            ZERO: state_nx = DONE;
            BUSY: begin
                // Flush wins over a same-cycle ready: the result is discarded.
                if (flush_i) begin
                    div_annul_o = 1'b1;
                    state_nx    = IDLE;
                end else if (div_ready_i) begin
                    state_nx = DONE;
                end else if (wdog_hit) begin
                    div_annul_o = 1'b1;
                    state_nx    = DONE;
                end
            end
            DONE: begin
                if (flush_i || !stall_i)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign div_start_o = (state == BUSY);
    assign stallreq_o  = div_req_i & (state != DONE);
    assign whilo_o     = (state == DONE) & ~flush_i;
    assign hi_o        = result[63:32];
    assign lo_o        = result[31:0];

endmodule

// File: tb/tb_ex_div_ctrl.sv
// Directed self-checking bench for ex_div_ctrl with a hand-driven divider ready/result model.
module tb_ex_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        div_req_i = 1'b0;
    logic        div_signed_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        flush_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_opdata1_o;
    logic [31:0] div_opdata2_o;
    logic [63:0] div_result_i = 64'd0;
    logic        div_ready_i = 1'b0;
    logic        stallreq_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div_err_o;

    int checks = 0;
    int errors = 0;

    ex_div_ctrl #(.WDOG_LIMIT(48)) dut (
        .clk(clk), .rst(rst),
        .div_req_i(div_req_i), .div_signed_i(div_signed_i),
        .opdata1_i(opdata1_i), .opdata2_i(opdata2_i),
        .flush_i(flush_i), .stall_i(stall_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o),
        .div_signed_o(div_signed_o), .div_opdata1_o(div_opdata1_o),
        .div_opdata2_o(div_opdata2_o), .div_result_i(div_result_i),
        .div_ready_i(div_ready_i), .stallreq_o(stallreq_o),
        .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o), .div_err_o(div_err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
             stallreq_o, whilo_o, hi_o, lo_o, div_err_o} !== 134'd0) begin
            errors++;
            $display("FAIL reset_outputs start=%b annul=%b whilo=%b hi=%h lo=%h err=%b expected all 0",
                     div_start_o, div_annul_o, whilo_o, hi_o, lo_o, div_err_o);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_divu();
        int st_cnt = 0;
        int busy_bad = 0;
        div_req_i = 1'b1; div_signed_i = 1'b0; opdata1_i = 32'd100; opdata2_i = 32'd7;
        div_result_i = {32'd2, 32'd14};
        for (int c = 0; c <= 33; c++) begin
            div_ready_i = (c == 32);
            #1;
            if (stallreq_o) st_cnt++;
            if (c == 0) begin
                checks++;
                if ({div_start_o, stallreq_o} !== 2'b01) begin
                    errors++;
                    $display("FAIL divu_cycle0 start=%b stallreq=%b expected start=0 stallreq=1", div_start_o, stallreq_o);
                end
            end
            if (c >= 1 && c <= 32 &&
                {div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o, whilo_o} !== {1'b1, 1'b0, 32'd100, 32'd7, 1'b0})
                busy_bad++;
            if (c == 33) begin
                checks++;
                if ({whilo_o, stallreq_o, div_start_o, hi_o, lo_o} !== {1'b1, 1'b0, 1'b0, 32'd2, 32'd14}) begin
                    errors++;
                    $display("FAIL divu_done whilo=%b stallreq=%b start=%b hi=%0d lo=%0d expected 1 0 0 2 14",
                             whilo_o, stallreq_o, div_start_o, hi_o, lo_o);
                end
                div_req_i = 1'b0;
            end
            tick();
        end
        div_ready_i = 1'b0;
        checks++;
        if (busy_bad !== 0) begin
            errors++;
            $display("FAIL divu_busy_outputs bad_cycles=%0d expected 0", busy_bad);
        end
        checks++;
        if (st_cnt !== 33) begin
            errors++;
            $display("FAIL divu_stall_cycles got %0d expected 33", st_cnt);
        end
        checks++;
        if (whilo_o !== 1'b0) begin
            errors++;
            $display("FAIL divu_single_write whilo=%b expected 0", whilo_o);
        end
    endtask

    task automatic test_div_signed();
        div_req_i = 1'b1; div_signed_i = 1'b1; opdata1_i = 32'hFFFF_FFF9; opdata2_i = 32'd2;
        div_result_i = {32'hFFFF_FFFF, 32'hFFFF_FFFD};
        for (int c = 0; c <= 6; c++) begin
            div_ready_i = (c == 5);
            #1;
            if (c == 1) begin
                checks++;
                if ({div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o} !== {1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2}) begin
                    errors++;
                    $display("FAIL div_signed_latch start=%b sgn=%b op1=%h op2=%h expected 1 1 fffffff9 00000002",
                             div_start_o, div_signed_o, div_opdata1_o, div_opdata2_o);
                end
            end
            if (c == 6) begin
                checks++;
                if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD}) begin
                    errors++;
                    $display("FAIL div_signed_result whilo=%b hi=%h lo=%h expected 1 ffffffff fffffffd", whilo_o, hi_o, lo_o);
                end
                div_req_i = 1'b0;
            end
            tick();
        end
        div_ready_i = 1'b0;
    endtask

    task automatic test_div_zero();
        logic start_seen = 1'b0;
        div_req_i = 1'b1; div_signed_i = 1'b1; opdata1_i = 32'd1234; opdata2_i = 32'd0;
        for (int c = 0; c <= 2; c++) begin
            #1;
            start_seen |= div_start_o;
            if (c == 1) begin
                checks++;
                if ({stallreq_o, whilo_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL div_zero_cycle1 stallreq=%b whilo=%b expected 1 0", stallreq_o, whilo_o);
                end
            end
            if (c == 2) begin
                checks++;
                if ({whilo_o, stallreq_o, hi_o, lo_o} !== {1'b1, 1'b0, 64'd0}) begin
                    errors++;
                    $display("FAIL div_zero_result whilo=%b stallreq=%b hi=%h lo=%h expected 1 0 0 0", whilo_o, stallreq_o, hi_o, lo_o);
                end
                div_req_i = 1'b0;
            end
            tick();
        end
        checks++;
        if (start_seen !== 1'b0) begin
            errors++;
            $display("FAIL div_zero_no_start start_seen=%b expected 0", start_seen);
        end
    endtask

    task automatic test_flush();
        logic whilo_seen = 1'b0;
        int annul_bad = 0;
        div_req_i = 1'b1; div_signed_i = 1'b0; opdata1_i = 32'd50; opdata2_i = 32'd5;
        div_result_i = {32'hAAAA_AAAA, 32'hBBBB_BBBB};
        for (int c = 0; c <= 11; c++) begin
            flush_i     = (c == 10);
            div_ready_i = (c == 10);
            #1;
            whilo_seen |= whilo_o;
            if (c != 10 && div_annul_o) annul_bad++;
            if (c == 10) begin
                checks++;
                if ({div_annul_o, div_start_o} !== 2'b11) begin
                    errors++;
                    $display("FAIL flush_annul annul=%b start=%b expected 1 1", div_annul_o, div_start_o);
                end
                div_req_i = 1'b0;
            end
            if (c == 11) begin
                checks++;
                if ({div_start_o, hi_o, lo_o} !== {1'b0, 64'd0}) begin
                    errors++;
                    $display("FAIL flush_abort start=%b hi=%h lo=%h expected 0 0 0", div_start_o, hi_o, lo_o);
                end
            end
            tick();
        end
        flush_i = 1'b0; div_ready_i = 1'b0;
        checks++;
        if ({whilo_seen, annul_bad} !== {1'b0, 32'd0}) begin
            errors++;
            $display("FAIL flush_no_write whilo_seen=%b extra_annul=%0d expected 0 0", whilo_seen, annul_bad);
        end
        div_req_i = 1'b1; opdata1_i = 32'd50; opdata2_i = 32'd5;
        div_result_i = {32'd0, 32'd10};
        for (int c = 0; c <= 4; c++) begin
            div_ready_i = (c == 3);
            #1;
            if (c == 4) begin
                checks++;
                if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'd0, 32'd10}) begin
                    errors++;
                    $display("FAIL flush_followup whilo=%b hi=%0d lo=%0d expected 1 0 10", whilo_o, hi_o, lo_o);
                end
                div_req_i = 1'b0;
            end
            tick();
        end
        div_ready_i = 1'b0;
    endtask

    task automatic test_stall_done();
        int stable = 0;
        div_req_i = 1'b1; div_signed_i = 1'b0; opdata1_i = 32'd9; opdata2_i = 32'd4;
        div_result_i = {32'd1, 32'd2};
        for (int c = 0; c <= 7; c++) begin
            div_ready_i = (c == 2);
            stall_i     = (c >= 3 && c <= 5);
            if (c >= 3) div_req_i = 1'b0;
            #1;
            if (c >= 3 && c <= 6 && {whilo_o, hi_o, lo_o} === {1'b1, 32'd1, 32'd2}) stable++;
            if (c == 7) begin
                checks++;
                if ({whilo_o, div_start_o} !== 2'b00) begin
                    errors++;
                    $display("FAIL stall_exit whilo=%b start=%b expected 0 0", whilo_o, div_start_o);
                end
            end
            tick();
        end
        stall_i = 1'b0; div_ready_i = 1'b0;
        checks++;
        if (stable !== 4) begin
            errors++;
            $display("FAIL stall_done_hold stable_cycles=%0d expected 4", stable);
        end
    endtask

    task automatic test_reset_mid_busy();
        div_req_i = 1'b1; div_signed_i = 1'b1; opdata1_i = 32'd77; opdata2_i = 32'd3;
        tick(); tick(); tick();
        checks++;
        if (div_start_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_busy start=%b expected 1", div_start_o);
        end
        #2 rst = 1'b1; div_req_i = 1'b0;
        #1;
        checks++;
        if ({div_start_o, div_annul_o, div_signed_o, div_opdata1_o, div_opdata2_o,
             stallreq_o, whilo_o, hi_o, lo_o, div_err_o} !== 134'd0) begin
            errors++;
            $display("FAIL rst_mid_busy start=%b annul=%b sgn=%b op1=%h hi=%h lo=%h expected all 0",
                     div_start_o, div_annul_o, div_signed_o, div_opdata1_o, hi_o, lo_o);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        div_req_i = 1'b1; div_signed_i = 1'b0; opdata1_i = 32'd20; opdata2_i = 32'd3;
        for (int c = 0; c <= 7; c++) begin
            div_ready_i  = (c == 2) || (c == 4) || (c == 6);
            div_result_i = (c == 2) ? {32'd2, 32'd6} : (c == 4) ? {32'hFFFF_FFFF, 32'hFFFF_FFFF} : {32'd2, 32'd7};
            #1;
            if (c == 3) begin
                checks++;
                if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'd2, 32'd6}) begin
                    errors++;
                    $display("FAIL b2b_first whilo=%b hi=%0d lo=%0d expected 1 2 6", whilo_o, hi_o, lo_o);
                end
                opdata1_i = 32'd30; opdata2_i = 32'd4;
            end
            if (c == 4) begin
                checks++;
                if ({stallreq_o, div_start_o, whilo_o} !== 3'b100) begin
                    errors++;
                    $display("FAIL b2b_reaccept stallreq=%b start=%b whilo=%b expected 1 0 0", stallreq_o, div_start_o, whilo_o);
                end
            end
            if (c == 5) begin
                checks++;
                if ({div_start_o, div_opdata1_o, div_opdata2_o, hi_o, lo_o} !== {1'b1, 32'd30, 32'd4, 32'd2, 32'd6}) begin
                    errors++;
                    $display("FAIL b2b_second_busy start=%b op1=%0d op2=%0d hi=%h lo=%h expected 1 30 4 2 6",
                             div_start_o, div_opdata1_o, div_opdata2_o, hi_o, lo_o);
                end
            end
            if (c == 7) begin
                checks++;
                if ({whilo_o, hi_o, lo_o} !== {1'b1, 32'd2, 32'd7}) begin
                    errors++;
                    $display("FAIL b2b_second whilo=%b hi=%0d lo=%0d expected 1 2 7", whilo_o, hi_o, lo_o);
                end
                div_req_i = 1'b0;
            end
            tick();
        end
        div_ready_i = 1'b0;
    endtask

`ifdef DIV_WATCHDOG_EN
    task automatic test_watchdog();
        int annul_early = 0;
        div_req_i = 1'b1; div_signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd1;
        for (int c = 0; c <= 50; c++) begin
            #1;
            if (c < 48 && div_annul_o) annul_early++;
            if (c == 48) begin
                checks++;
                if ({div_annul_o, div_start_o} !== 2'b11) begin
                    errors++;
                    $display("FAIL wdog_annul annul=%b start=%b expected 1 1", div_annul_o, div_start_o);
                end
            end
            if (c == 49) begin
                checks++;
                if ({whilo_o, div_err_o, hi_o, lo_o} !== {1'b1, 1'b1, 64'd0}) begin
                    errors++;
                    $display("FAIL wdog_done whilo=%b err=%b hi=%h lo=%h expected 1 1 0 0", whilo_o, div_err_o, hi_o, lo_o);
                end
                div_req_i = 1'b0;
            end
            if (c == 50) begin
                checks++;
                if ({div_err_o, whilo_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL wdog_sticky err=%b whilo=%b expected 1 0", div_err_o, whilo_o);
                end
                div_req_i = 1'b1; opdata2_i = 32'd0;
            end
            tick();
        end
        checks++;
        if ({annul_early, div_err_o} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL wdog_clear early_annul=%0d err=%b expected 0 0", annul_early, div_err_o);
        end
        div_req_i = 1'b0;
        tick(); tick();
    endtask
`else
    task automatic test_watchdog();
        int annul_seen = 0;
        div_req_i = 1'b1; div_signed_i = 1'b0; opdata1_i = 32'd5; opdata2_i = 32'd1;
        for (int c = 0; c <= 61; c++) begin
            flush_i = (c == 60);
            #1;
            if (c < 60 && (div_annul_o || div_err_o || whilo_o)) annul_seen++;
            if (c == 60) begin
                checks++;
                if ({div_start_o, div_err_o} !== 2'b10) begin
                    errors++;
                    $display("FAIL nowdog_still_busy start=%b err=%b expected 1 0", div_start_o, div_err_o);
                end
                div_req_i = 1'b0;
            end
            tick();
        end
        flush_i = 1'b0;
        checks++;
        if ({annul_seen, div_start_o} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL nowdog_events unexpected=%0d start=%b expected 0 0", annul_seen, div_start_o);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_flush();
        test_stall_done();
        test_reset_mid_busy();
        test_back_to_back();
        test_watchdog();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
